// File: rtl/i2c_cmd_queue.sv
// i2c_cmd_queue: buffers single-byte I2C read/write commands and issues them to i2c_master one at a time
// Ports: sysclk/reset (sync, active-high); cmd_valid/cmd_ready/cmd_rw/cmd_addr/cmd_data command push;
//        rsp_valid/rsp_ready/rsp_data read-byte pop; m_enable/m_rw/m_address/m_wdata/m_rdata/m_busy master side;
//        cmd_count/rsp_count/idle status; timeout_err sticky flag.
// Optional feature: define I2C_CMDQ_TIMEOUT_EN to abort a transaction after TIMEOUT_CYCLES (timeout_err tied 0 otherwise).
module i2c_cmd_queue #(
  parameter int CMD_DEPTH = 8,
  parameter int RSP_DEPTH = 8,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic                           sysclk,
  input  logic                           reset,
  input  logic                           cmd_valid,
  output logic                           cmd_ready,
  input  logic                           cmd_rw,
  input  logic [6:0]                     cmd_addr,
  input  logic [7:0]                     cmd_data,
  output logic                           rsp_valid,
  input  logic                           rsp_ready,
  output logic [7:0]                     rsp_data,
  output logic                           m_enable,
  output logic                           m_rw,
  output logic [6:0]                     m_address,
  output logic [7:0]                     m_wdata,
  input  logic [7:0]                     m_rdata,
  input  logic                           m_busy,
  output logic [$clog2(CMD_DEPTH+1)-1:0] cmd_count,
  output logic [$clog2(RSP_DEPTH+1)-1:0] rsp_count,
  output logic                           idle,
  output logic                           timeout_err
);
  localparam int CW = $clog2(CMD_DEPTH);
  localparam int CC = $clog2(CMD_DEPTH + 1);
  localparam int RW = $clog2(RSP_DEPTH);
  localparam int RC = $clog2(RSP_DEPTH + 1);
  localparam logic [CC-1:0] CMD_FULL = CC'(CMD_DEPTH);
  localparam logic [RC-1:0] RSP_FULL = RC'(RSP_DEPTH);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DONE, CAPTURE} state_t;
  state_t state, state_n;
  logic [15:0] cmd_mem [CMD_DEPTH];
  logic [7:0] rsp_mem [RSP_DEPTH];
  logic [CW-1:0] cmd_wr, cmd_rd;
  logic [RW-1:0] rsp_wr, rsp_rd;
  logic reserved, cmd_push, load, rsp_push, rsp_pop, head_rw, tmo;
  logic [7:0] rsp_wdata;
  assign cmd_ready = cmd_count != CMD_FULL;
  assign cmd_push = cmd_valid && cmd_ready;
  assign rsp_valid = rsp_count != '0;
  assign rsp_pop = rsp_valid && rsp_ready;
  assign head_rw = cmd_mem[cmd_rd][15];
  assign idle = state == IDLE && cmd_count == '0;
`ifdef I2C_CMDQ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tcnt;
  logic terr;
  // Only IDLE precedes ISSUE, so clearing in IDLE gives a zero count on ISSUE entry.
  assign tmo = (state == ISSUE || state == WAIT_DONE) && tcnt == TW'(TIMEOUT_CYCLES - 1);
  assign timeout_err = terr;
  always_ff @(posedge sysclk) begin
    if (reset) begin
      tcnt <= '0;
      terr <= 1'b0;
    end else begin
      tcnt <= state == IDLE ? '0 : tcnt + TW'(1);
      terr <= terr | tmo;
    end
  end
`else
  assign tmo = 1'b0;
  assign timeout_err = 1'b0;
`endif
  always_comb begin
    state_n = state;
    load = 1'b0;
    rsp_push = 1'b0;
    rsp_wdata = m_rdata;
    if (tmo) begin
      // An aborted read still fills its reserved slot so responses stay in command order.
      state_n = IDLE;
      rsp_push = reserved;
      rsp_wdata = 8'h00;
    end else begin
      case (state)
        IDLE: if (cmd_count != '0 && (!head_rw || rsp_count + RC'(reserved) < RSP_FULL)) begin
          load = 1'b1;
          state_n = ISSUE;
        end
        ISSUE:     state_n = m_busy ? WAIT_DONE : ISSUE;
        WAIT_DONE: state_n = m_busy ? WAIT_DONE : (m_rw ? CAPTURE : IDLE);
        CAPTURE: begin
          rsp_push = 1'b1;
          state_n = IDLE;
        end
      endcase
    end
  end
  always_ff @(posedge sysclk) begin
    if (reset) begin
      state <= IDLE;
      cmd_wr <= '0;
      cmd_rd <= '0;
      cmd_count <= '0;
      rsp_wr <= '0;
      rsp_rd <= '0;
      rsp_count <= '0;
      rsp_data <= '0;
      reserved <= 1'b0;
      m_enable <= 1'b0;
      m_rw <= 1'b0;
      m_address <= '0;
      m_wdata <= '0;
    end else begin
      state <= state_n;
      m_enable <= state_n == ISSUE;
      if (cmd_push) begin
        cmd_mem[cmd_wr] <= {cmd_rw, cmd_addr, cmd_data};
        cmd_wr <= cmd_wr + CW'(1);
      end
      if (load) begin
        {m_rw, m_address, m_wdata} <= cmd_mem[cmd_rd];
        cmd_rd <= cmd_rd + CW'(1);
      end
      cmd_count <= cmd_count + CC'(cmd_push) - CC'(load);
      reserved <= load ? head_rw : (rsp_push ? 1'b0 : reserved);
      if (rsp_push) begin
        rsp_mem[rsp_wr] <= rsp_wdata;
        rsp_wr <= rsp_wr + RW'(1);
      end
      if (rsp_pop) rsp_rd <= rsp_rd + RW'(1);
      rsp_count <= rsp_count + RC'(rsp_push) - RC'(rsp_pop);
      // rsp_data tracks the head entry and keeps its last value once the FIFO drains.
      if (rsp_pop && rsp_count > RC'(1)) rsp_data <= rsp_mem[rsp_rd + RW'(1)];
      else if (rsp_push && (rsp_count == '0 || (rsp_pop && rsp_count == RC'(1)))) rsp_data <= rsp_wdata;
    end
  end
endmodule

// File: tb/tb_i2c_cmd_queue.sv
// tb_i2c_cmd_queue: self-checking bench for i2c_cmd_queue with a stub I2C master and queue-based reference model
module tb_i2c_cmd_queue;
  logic sysclk = 1'b0, reset = 1'b1, cmd_valid = 1'b0, cmd_rw = 1'b0, rsp_ready = 1'b0, m_busy = 1'b0;
  logic [6:0] cmd_addr = '0;
  logic [7:0] cmd_data = '0, m_rdata = '0;
  logic cmd_ready, rsp_valid, m_enable, m_rw, idle, timeout_err;
  logic [7:0] rsp_data, m_wdata;
  logic [6:0] m_address;
  logic [3:0] cmd_count, rsp_count;
  int total = 0, bad = 0;
  logic [15:0] exp_cmd[$], issued[$];
  logic [7:0] exp_rsp[$];
  int en_delay = 0, busy_len = 1;
  bit rnd_timing = 0, hold_busy = 0, never_busy = 0;
  logic [7:0] stub_val = '0;

  i2c_cmd_queue #(.CMD_DEPTH(8), .RSP_DEPTH(8), .TIMEOUT_CYCLES(50)) dut (
    .sysclk(sysclk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rw(cmd_rw),
    .cmd_addr(cmd_addr), .cmd_data(cmd_data), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .m_enable(m_enable), .m_rw(m_rw), .m_address(m_address), .m_wdata(m_wdata),
    .m_rdata(m_rdata), .m_busy(m_busy), .cmd_count(cmd_count), .rsp_count(rsp_count), .idle(idle),
    .timeout_err(timeout_err)
  );

  always #5 sysclk = ~sysclk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Stub master: logs each transaction it sees, raises busy after a delay, returns a read byte.
  always begin : stub
    int d, l;
    logic [7:0] v;
    @(posedge sysclk);
    #1;
    if (m_enable && !never_busy && !reset) begin
      issued.push_back({m_rw, m_address, m_wdata});
      d = rnd_timing ? int'($urandom_range(0, 6)) : en_delay;
      l = rnd_timing ? int'($urandom_range(1, 10)) : busy_len;
      v = rnd_timing ? 8'($urandom) : stub_val;
      repeat (d) @(posedge sysclk);
      #1;
      m_busy = 1'b1;
      m_rdata = v;
      if (m_rw) exp_rsp.push_back(v);
      repeat (l) @(posedge sysclk);
      while (hold_busy) @(posedge sysclk);
      #1 m_busy = 1'b0;
    end
  end

  task automatic push_cmd(input logic rw, input logic [6:0] a, input logic [7:0] d);
    int n = 0;
    @(negedge sysclk);
    cmd_valid = 1'b1; cmd_rw = rw; cmd_addr = a; cmd_data = d;
    while (!cmd_ready && n < 2000) begin @(negedge sysclk); n++; end
    total++;
    if (cmd_ready !== 1'b1) begin bad++; $display("FAIL push_wait: cmd_ready=%b want 1", cmd_ready); end
    else exp_cmd.push_back({rw, a, d});
    @(negedge sysclk);
    cmd_valid = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge sysclk);
    reset = 1'b0;
    total++;
    if ({cmd_ready, rsp_valid, m_enable, m_rw, idle, timeout_err} !== 6'b100010) begin
      bad++; $display("FAIL reset_flags: got %b want 100010", {cmd_ready, rsp_valid, m_enable, m_rw, idle, timeout_err});
    end
    total++;
    if ({m_address, m_wdata, rsp_data} !== 23'h0) begin
      bad++; $display("FAIL reset_data: got %h want 0", {m_address, m_wdata, rsp_data});
    end
    total++;
    if (cmd_count !== 4'd0 || rsp_count !== 4'd0) begin
      bad++; $display("FAIL reset_counts: got %0d/%0d want 0/0", cmd_count, rsp_count);
    end
  endtask

  task automatic test_write();
    int n = 0;
    en_delay = 5; busy_len = 20;
    push_cmd(1'b0, 7'h50, 8'h3C);
    total++;
    if (m_enable !== 1'b0) begin bad++; $display("FAIL write_en_early: got %b want 0", m_enable); end
    total++;
    if (cmd_count !== 4'd1) begin bad++; $display("FAIL write_queued: got %0d want 1", cmd_count); end
    @(negedge sysclk);
    total++;
    if (m_enable !== 1'b1) begin bad++; $display("FAIL write_en_rise: got %b want 1", m_enable); end
    total++;
    if ({m_rw, m_address, m_wdata} !== {1'b0, 7'h50, 8'h3C}) begin
      bad++; $display("FAIL write_fields: got %h want 503c", {m_rw, m_address, m_wdata});
    end
    while (m_enable === 1'b1 && n < 100) begin n++; @(negedge sysclk); end
    total++;
    if (n != en_delay + 1) begin bad++; $display("FAIL write_en_width: got %0d want %0d", n, en_delay + 1); end
    total++;
    if (m_busy !== 1'b1) begin bad++; $display("FAIL write_en_drop: busy=%b want 1", m_busy); end
    n = 0;
    while (!(idle && !m_busy) && n < 200) begin @(negedge sysclk); n++; end
    total++;
    if (!(idle === 1'b1 && m_busy === 1'b0)) begin bad++; $display("FAIL write_idle: idle=%b want 1", idle); end
    total++;
    if (rsp_count !== 4'd0 || rsp_valid !== 1'b0) begin
      bad++; $display("FAIL write_no_rsp: count=%0d want 0", rsp_count);
    end
    total++;
    if (issued.size() != 1 || issued[0] !== 16'h503C) begin
      bad++; $display("FAIL write_issued: size=%0d want 1", issued.size());
    end
    issued.delete(); exp_cmd.delete(); exp_rsp.delete();
  endtask

  task automatic test_read();
    int n = 0;
    logic [2:0] seq;
    en_delay = 2; busy_len = 4; stub_val = 8'hA5;
    push_cmd(1'b1, 7'h21, 8'h00);
    while (m_busy !== 1'b1 && n < 100) begin @(negedge sysclk); n++; end
    while (m_busy !== 1'b0 && n < 200) begin @(negedge sysclk); n++; end
    seq[2] = rsp_valid;
    @(negedge sysclk); seq[1] = rsp_valid;
    @(negedge sysclk); seq[0] = rsp_valid;
    total++;
    if (seq !== 3'b001) begin bad++; $display("FAIL read_rsp_timing: got %b want 001", seq); end
    total++;
    if (rsp_data !== 8'hA5 || rsp_count !== 4'd1) begin
      bad++; $display("FAIL read_rsp: data=%h count=%0d want a5/1", rsp_data, rsp_count);
    end
    total++;
    if (m_rw !== 1'b1 || m_address !== 7'h21) begin
      bad++; $display("FAIL read_fields: got %b/%h want 1/21", m_rw, m_address);
    end
    rsp_ready = 1'b1;
    @(negedge sysclk);
    rsp_ready = 1'b0;
    total++;
    if (rsp_count !== 4'd0 || rsp_valid !== 1'b0 || rsp_data !== 8'hA5) begin
      bad++; $display("FAIL read_pop: count=%0d valid=%b data=%h want 0/0/a5", rsp_count, rsp_valid, rsp_data);
    end
    issued.delete(); exp_cmd.delete(); exp_rsp.delete();
  endtask

  task automatic test_cmd_full();
    int n = 0;
    bit stuck = 1;
    en_delay = 0; busy_len = 1; hold_busy = 1;
    push_cmd(1'b0, 7'h10, 8'h00);
    while (m_busy !== 1'b1 && n < 100) begin @(negedge sysclk); n++; end
    for (int i = 1; i <= 8; i++) push_cmd(1'b0, 7'(8'h10 + i), 8'($urandom));
    total++;
    if (cmd_count !== 4'd8 || cmd_ready !== 1'b0) begin
      bad++; $display("FAIL full_count: count=%0d ready=%b want 8/0", cmd_count, cmd_ready);
    end
    cmd_valid = 1'b1; cmd_rw = 1'b0; cmd_addr = 7'h19; cmd_data = 8'h99;
    repeat (3) begin @(negedge sysclk); stuck &= (cmd_count === 4'd8 && cmd_ready === 1'b0); end
    total++;
    if (!stuck) begin bad++; $display("FAIL full_refuse: count=%0d want 8", cmd_count); end
    hold_busy = 0;
    n = 0;
    while (cmd_count === 4'd8 && n < 100) begin @(negedge sysclk); n++; end
    total++;
    if (cmd_count !== 4'd7 || cmd_ready !== 1'b1) begin
      bad++; $display("FAIL full_pop: count=%0d want 7", cmd_count);
    end
    @(negedge sysclk);
    cmd_valid = 1'b0;
    exp_cmd.push_back({1'b0, 7'h19, 8'h99});
    total++;
    if (cmd_count !== 4'd8) begin bad++; $display("FAIL full_refill: count=%0d want 8", cmd_count); end
    n = 0;
    while (!(idle && !m_busy) && n < 500) begin @(negedge sysclk); n++; end
    total++;
    if (issued.size() != exp_cmd.size()) begin
      bad++; $display("FAIL full_issued_n: got %0d want %0d", issued.size(), exp_cmd.size());
    end else foreach (exp_cmd[i]) begin
      total++;
      if (issued[i] !== exp_cmd[i]) begin bad++; $display("FAIL full_order: got %h want %h", issued[i], exp_cmd[i]); end
    end
    issued.delete(); exp_cmd.delete(); exp_rsp.delete();
  endtask

  task automatic test_rsp_full();
    int n = 0;
    bit blocked = 1;
    logic [7:0] e;
    rnd_timing = 1;
    for (int i = 0; i < 9; i++) push_cmd(1'b1, 7'($urandom), 8'h00);
    while (rsp_count !== 4'd8 && n < 1000) begin @(negedge sysclk); n++; end
    total++;
    if (rsp_count !== 4'd8) begin bad++; $display("FAIL rspfull_count: got %0d want 8", rsp_count); end
    repeat (20) begin @(negedge sysclk); blocked &= (m_enable === 1'b0 && cmd_count === 4'd1); end
    total++;
    if (!blocked) begin bad++; $display("FAIL rspfull_block: en=%b count=%0d want 0/1", m_enable, cmd_count); end
    n = 0;
    while (exp_rsp.size() != 0 && n < 2000) begin
      if (rsp_valid === 1'b1) begin
        e = exp_rsp.pop_front();
        total++;
        if (rsp_data !== e) begin bad++; $display("FAIL rspfull_data: got %h want %h", rsp_data, e); end
        rsp_ready = 1'b1;
      end
      @(negedge sysclk);
      rsp_ready = 1'b0;
      n++;
    end
    n = 0;
    while (!(idle && rsp_count == 0) && n < 500) begin @(negedge sysclk); n++; end
    total++;
    if (issued.size() != 9 || exp_rsp.size() != 0 || rsp_count !== 4'd0) begin
      bad++; $display("FAIL rspfull_drain: issued=%0d left=%0d want 9/0", issued.size(), exp_rsp.size());
    end else foreach (exp_cmd[i]) begin
      total++;
      if (issued[i] !== exp_cmd[i]) begin bad++; $display("FAIL rspfull_order: got %h want %h", issued[i], exp_cmd[i]); end
    end
    rnd_timing = 0;
    issued.delete(); exp_cmd.delete(); exp_rsp.delete();
  endtask

  task automatic test_random();
    int sent = 0, c = 0;
    logic [7:0] e;
    rnd_timing = 1;
    for (c = 0; c < 6000 && !(sent == 40 && !cmd_valid && idle && !m_busy && rsp_count == 0); c++) begin
      @(negedge sysclk);
      rsp_ready = 1'b0;
      if (rsp_valid === 1'b1 && $urandom_range(0, 2) != 0) begin
        e = exp_rsp.size() != 0 ? exp_rsp.pop_front() : 8'hxx;
        total++;
        if (rsp_data !== e) begin bad++; $display("FAIL rand_rsp: got %h want %h", rsp_data, e); end
        rsp_ready = 1'b1;
      end
      cmd_valid = 1'b0;
      if (sent < 40 && $urandom_range(0, 1) == 1) begin
        cmd_valid = 1'b1; cmd_rw = 1'($urandom); cmd_addr = 7'($urandom); cmd_data = 8'($urandom);
        if (cmd_ready) begin exp_cmd.push_back({cmd_rw, cmd_addr, cmd_data}); sent++; end
      end
    end
    cmd_valid = 1'b0; rsp_ready = 1'b0; rnd_timing = 0;
    total++;
    if (sent != 40 || rsp_count !== 4'd0 || exp_rsp.size() != 0) begin
      bad++; $display("FAIL rand_drain: sent=%0d rsp=%0d left=%0d want 40/0/0", sent, rsp_count, exp_rsp.size());
    end
    total++;
    if (issued.size() != exp_cmd.size()) begin
      bad++; $display("FAIL rand_issued_n: got %0d want %0d", issued.size(), exp_cmd.size());
    end else foreach (exp_cmd[i]) begin
      total++;
      if (issued[i] !== exp_cmd[i]) begin bad++; $display("FAIL rand_order: got %h want %h", issued[i], exp_cmd[i]); end
    end
    total++;
    if (timeout_err !== 1'b0) begin bad++; $display("FAIL rand_timeout: got %b want 0", timeout_err); end
    issued.delete(); exp_cmd.delete(); exp_rsp.delete();
  endtask

  task automatic test_reset_mid();
    int n = 0;
    en_delay = 1; busy_len = 1; hold_busy = 1;
    push_cmd(1'b1, 7'h33, 8'h00);
    while (m_busy !== 1'b1 && n < 100) begin @(negedge sysclk); n++; end
    push_cmd(1'b0, 7'h34, 8'h55);
    total++;
    if (cmd_count !== 4'd1 || m_enable !== 1'b0) begin
      bad++; $display("FAIL mid_setup: count=%0d en=%b want 1/0", cmd_count, m_enable);
    end
    reset = 1'b1;
    @(negedge sysclk);
    total++;
    if ({m_enable, idle, rsp_valid} !== 3'b010 || cmd_count !== 4'd0 || rsp_count !== 4'd0) begin
      bad++; $display("FAIL mid_reset: en/idle/rv=%b counts=%0d/%0d want 010 0/0", {m_enable, idle, rsp_valid}, cmd_count, rsp_count);
    end
    reset = 1'b0; hold_busy = 0;
    n = 0;
    while (m_busy !== 1'b0 && n < 100) begin @(negedge sysclk); n++; end
    repeat (3) @(negedge sysclk);
    total++;
    if (m_enable !== 1'b0 || idle !== 1'b1) begin
      bad++; $display("FAIL mid_after: en=%b idle=%b want 0/1", m_enable, idle);
    end
    issued.delete(); exp_cmd.delete(); exp_rsp.delete();
  endtask

`ifdef I2C_CMDQ_TIMEOUT_EN
  task automatic test_timeout();
    int n = 0;
    never_busy = 1;
    push_cmd(1'b1, 7'h44, 8'h00);
    @(negedge sysclk);
    while (m_enable === 1'b1 && n < 200) begin n++; @(negedge sysclk); end
    total++;
    if (n != 50) begin bad++; $display("FAIL tmo_width: got %0d want 50", n); end
    total++;
    if (timeout_err !== 1'b1 || rsp_valid !== 1'b1 || rsp_data !== 8'h00) begin
      bad++; $display("FAIL tmo_rsp: err=%b valid=%b data=%h want 1/1/00", timeout_err, rsp_valid, rsp_data);
    end
    never_busy = 0;
  endtask
`endif

  initial begin
    test_reset();
    test_write();
    test_read();
    test_cmd_full();
    test_rsp_full();
    test_random();
    test_reset_mid();
`ifdef I2C_CMDQ_TIMEOUT_EN
    test_timeout();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
